// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer: advances the PC, freezes on unresolved branches, redirects on taken ones.
// All outputs are registered; stall_in freezes fetch without losing the current PC.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic        j_accept,
  input  logic        j_wait,
  input  logic [31:0] j_addr,
  input  logic        stall_in,
  output logic [31:0] pc_addr,
  output logic        fetch_valid,
  output logic        flush,
  output logic        hold,
  output logic        misalign_err,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fv_q, fv_d;
  logic        fresh_q, fresh_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;
  logic        taken, waiting, redirect, advance;

  assign taken   = br_valid & j_accept;
  assign waiting = br_valid & j_wait & ~j_accept;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fv_d     = 1'b0;
    fresh_d  = fresh_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;
    redirect = 1'b0;
    advance  = 1'b0;

    case (state_q)
      RUN: begin
        if (taken)        redirect = 1'b1;
        else if (waiting) state_d  = HOLD;
        else              advance  = 1'b1;
      end
      HOLD: begin
        if (taken) begin
          redirect = 1'b1;
        end else if (!waiting) begin
          state_d = RUN;
          advance = 1'b1;
        end
      end
      FLUSH: begin
        state_d = RUN;
        advance = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (redirect) begin
      state_d = FLUSH;
      pc_d    = {j_addr[31:2], 2'b00};
      fresh_d = 1'b0;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (j_addr[1:0] != 2'b00) mis_d = 1'b1;
    end

    // The reset PC has never been issued, so the first advance presents it instead of skipping it.
    if (advance && !stall_in) begin
      fv_d    = 1'b1;
      fresh_d = 1'b0;
      if (!fresh_q) pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      fresh_q <= 1'b1;
      mis_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      fresh_q <= fresh_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_addr      = pc_q;
  assign fetch_valid  = fv_q;
  assign flush        = (state_q == FLUSH);
  assign hold         = (state_q == HOLD);
  assign misalign_err = mis_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each scenario queues stimulus with its expected outputs.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, br_valid, j_accept, j_wait, stall_in;
  logic [31:0] j_addr;
  logic [31:0] pc_addr;
  logic        fetch_valid, flush, hold, misalign_err;
  logic [15:0] redirect_cnt;

  pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .j_accept(j_accept), .j_wait(j_wait),
    .j_addr(j_addr), .stall_in(stall_in), .pc_addr(pc_addr), .fetch_valid(fetch_valid),
    .flush(flush), .hold(hold), .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc; logic fv; logic fl; logic hd; logic me; logic [15:0] cnt;
  } obs_t;
  typedef struct packed {
    logic r; logic b; logic a; logic w; logic s; logic [31:0] ad;
  } stim_t;

  obs_t  exp_q[$];
  stim_t stim_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic obs_t E(input logic [31:0] pc, input logic fv, input logic fl,
                             input logic hd, input logic me, input logic [15:0] cnt);
    obs_t o;
    o.pc = pc; o.fv = fv; o.fl = fl; o.hd = hd; o.me = me; o.cnt = cnt;
    return o;
  endfunction

  function automatic stim_t S(input logic r, input logic b, input logic a, input logic w,
                              input logic s, input logic [31:0] ad);
    stim_t x;
    x.r = r; x.b = b; x.a = a; x.w = w; x.s = s; x.ad = ad;
    return x;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc = pc_addr; o.fv = fetch_valid; o.fl = flush; o.hd = hold;
    o.me = misalign_err; o.cnt = redirect_cnt;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h fv=%b flush=%b hold=%b mis=%b cnt=%h", o.pc, o.fv, o.fl, o.hd, o.me, o.cnt);
  endfunction

  task automatic push(input stim_t s, input obs_t x);
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  // Applies the front stimulus at the falling edge and lets one rising edge consume it.
  task automatic step();
    stim_t s;
    s = stim_q.pop_front();
    rst = s.r; br_valid = s.b; j_accept = s.a; j_wait = s.w; stall_in = s.s; j_addr = s.ad;
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] Z = 32'h0;

  task automatic test_reset();
    obs_t got, want;
    push(S(1, 1, 1, 0, 0, 32'h0000_1237), E(Z, 0, 0, 0, 0, 16'h0));
    push(S(1, 1, 0, 1, 1, 32'hDEAD_BEEF), E(Z, 0, 0, 0, 0, 16'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_run_seq();
    obs_t got, want;
    for (int i = 0; i < 5; i++) push(S(0, 0, 0, 0, 0, Z), E(32'(4 * i), 1, 0, 0, 0, 16'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL run_seq[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_hold_redirect();
    obs_t got, want;
    for (int i = 0; i < 3; i++) push(S(0, 1, 0, 1, 0, Z), E(32'h10, 0, 0, 1, 0, 16'h0));
    push(S(0, 1, 1, 0, 0, 32'h200), E(32'h200, 0, 1, 0, 0, 16'h1));
    push(S(0, 0, 0, 0, 0, Z),       E(32'h204, 1, 0, 0, 0, 16'h1));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL hold_redirect[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_stall_nottaken();
    obs_t got, want;
    push(S(0, 0, 0, 0, 1, Z), E(32'h204, 0, 0, 0, 0, 16'h1));
    push(S(0, 0, 0, 0, 1, Z), E(32'h204, 0, 0, 0, 0, 16'h1));
    push(S(0, 0, 0, 0, 0, Z), E(32'h208, 1, 0, 0, 0, 16'h1));
    push(S(0, 1, 0, 0, 0, Z), E(32'h20C, 1, 0, 0, 0, 16'h1));
    push(S(0, 1, 0, 0, 1, Z), E(32'h20C, 0, 0, 0, 0, 16'h1));
    push(S(0, 1, 0, 1, 0, Z), E(32'h20C, 0, 0, 1, 0, 16'h1));
    push(S(0, 1, 0, 0, 1, Z), E(32'h20C, 0, 0, 0, 0, 16'h1));
    push(S(0, 0, 0, 0, 0, Z), E(32'h210, 1, 0, 0, 0, 16'h1));
    push(S(0, 1, 0, 1, 0, Z), E(32'h210, 0, 0, 1, 0, 16'h1));
    push(S(0, 0, 0, 1, 0, Z), E(32'h214, 1, 0, 0, 0, 16'h1));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL stall_nottaken[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_misalign();
    obs_t got, want;
    push(S(0, 1, 1, 1, 1, 32'h102), E(32'h100, 0, 1, 0, 1, 16'h2));
    push(S(0, 0, 0, 0, 1, Z),       E(32'h100, 0, 0, 0, 1, 16'h2));
    push(S(0, 0, 0, 0, 0, Z),       E(32'h104, 1, 0, 0, 1, 16'h2));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL misalign[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want;
    push(S(0, 1, 1, 0, 0, 32'h400), E(32'h400, 0, 1, 0, 1, 16'h3));
    push(S(0, 0, 0, 0, 0, Z),       E(32'h404, 1, 0, 0, 1, 16'h3));
    push(S(0, 1, 1, 0, 0, 32'h803), E(32'h800, 0, 1, 0, 1, 16'h4));
    push(S(0, 0, 0, 0, 0, Z),       E(32'h804, 1, 0, 0, 1, 16'h4));
    push(S(0, 1, 0, 1, 0, Z),       E(32'h804, 0, 0, 1, 1, 16'h4));
    push(S(0, 1, 1, 1, 0, 32'h900), E(32'h900, 0, 1, 0, 1, 16'h5));
    push(S(0, 0, 0, 0, 0, Z),       E(32'h904, 1, 0, 0, 1, 16'h5));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_wrap();
    obs_t got, want;
    push(S(0, 1, 1, 0, 0, 32'hFFFF_FFF8), E(32'hFFFF_FFF8, 0, 1, 0, 1, 16'h6));
    push(S(0, 0, 0, 0, 0, Z),             E(32'hFFFF_FFFC, 1, 0, 0, 1, 16'h6));
    push(S(0, 0, 0, 0, 0, Z),             E(32'h0000_0000, 1, 0, 0, 1, 16'h6));
    push(S(0, 0, 0, 0, 0, Z),             E(32'h0000_0004, 1, 0, 0, 1, 16'h6));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL wrap[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    push(S(0, 1, 0, 1, 0, Z),      E(32'h4, 0, 0, 1, 1, 16'h6));
    push(S(1, 1, 0, 1, 0, Z),      E(Z, 0, 0, 0, 0, 16'h0));
    push(S(0, 0, 0, 0, 0, Z),      E(Z, 1, 0, 0, 0, 16'h0));
    push(S(0, 0, 0, 0, 0, Z),      E(32'h4, 1, 0, 0, 0, 16'h0));
    push(S(0, 1, 1, 0, 0, 32'h40), E(32'h40, 0, 1, 0, 0, 16'h1));
    push(S(1, 1, 1, 0, 0, 32'h81), E(Z, 0, 0, 0, 0, 16'h0));
    push(S(0, 0, 0, 0, 1, Z),      E(Z, 0, 0, 0, 0, 16'h0));
    push(S(0, 0, 0, 0, 0, Z),      E(Z, 1, 0, 0, 0, 16'h0));
    push(S(0, 0, 0, 0, 0, Z),      E(32'h4, 1, 0, 0, 0, 16'h0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset_mid[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  task automatic test_saturation();
    obs_t got, want;
    // Stands in for tens of thousands of redirects: preload the count just below its ceiling.
    force dut.cnt_q = 16'hFFFE;
    #1 release dut.cnt_q;
    push(S(0, 1, 1, 0, 0, 32'h40), E(32'h40, 0, 1, 0, 0, 16'hFFFF));
    push(S(0, 0, 0, 0, 0, Z),      E(32'h44, 1, 0, 0, 0, 16'hFFFF));
    push(S(0, 1, 1, 0, 0, 32'h80), E(32'h80, 0, 1, 0, 0, 16'hFFFF));
    push(S(0, 0, 0, 0, 0, Z),      E(32'h84, 1, 0, 0, 0, 16'hFFFF));
    for (int i = 0; stim_q.size() > 0; i++) begin
      step(); got = sample(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL saturation[%0d]: got %s want %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; j_accept = 1'b0; j_wait = 1'b0; stall_in = 1'b0; j_addr = 32'h0;
    @(negedge clk);
    test_reset();
    test_run_seq();
    test_hold_redirect();
    test_stall_nottaken();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
